// File: rtl/sign_restore.sv
// Purpose: queue operand signs in issue order and re-apply them to returning unsigned magnitudes as saturated two's complement.
// Latency: f_o/f_valid_o/sat_o are registered one cycle after mag_valid_i. count_o/in_full_o and err_o also update one cycle after the event.
// Backpressure: none downstream. A push into a full queue without a same-cycle pop is dropped and sets sticky err_o.
module sign_restore #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                         clk_i,
    input  logic                         reset_l_i,
    input  logic                         in_sign_i,
    input  logic                         in_push_i,
    output logic                         in_full_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    input  logic [WIDTH-1:0]             mag_i,
    input  logic                         mag_valid_i,
    output logic [WIDTH-1:0]             f_o,
    output logic                         f_valid_o,
    output logic                         sat_o,
    output logic                         err_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
    localparam logic [WIDTH-1:0] POS_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] NEG_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

    // Sign storage. It is not reset because the pointers and count define which entries are live.
    logic              mem_q [DEPTH];
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [WIDTH-1:0]  f_q, f_d;
    logic              f_valid_q, f_valid_d;
    logic              sat_q, sat_d;
    logic              err_q, err_d;

    logic              full;
    logic              empty;
    logic              push_ok;
    logic              pop_ok;
    logic              bypass;
    logic              mem_we;
    logic              sign_sel;
    logic [WIDTH-1:0]  conv_f;
    logic              conv_sat;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // When the queue is full, a same-cycle pop frees the slot, so the push is still accepted.
    // When the queue is empty, a same-cycle push supplies the sign that the pop needs.
    assign push_ok = in_push_i   && (!full  || mag_valid_i);
    assign pop_ok  = mag_valid_i && (!empty || in_push_i);
    assign bypass  = mag_valid_i && in_push_i && empty;

    // On a bypass the sign never lands in storage. Both pointers still advance so the queue stays empty.
    assign mem_we   = push_ok && !bypass;
    assign sign_sel = bypass ? in_sign_i : mem_q[rptr_q];

    // Convert magnitude to signed, clamping to the representable range.
    // For a negative sign, a magnitude of exactly 2^(W-1) maps to the most-negative code without saturating.
    always_comb begin
        conv_f   = mag_i;
        conv_sat = 1'b0;
        if (!sign_sel) begin
            if (mag_i[WIDTH-1]) begin
                conv_f   = POS_MAX;
                conv_sat = 1'b1;
            end
        end else begin
            if (mag_i[WIDTH-1] && (mag_i[WIDTH-2:0] != '0)) begin
                conv_f   = NEG_MIN;
                conv_sat = 1'b1;
            end else begin
                conv_f = -mag_i;
            end
        end
    end

    // Next-state for pointers, occupancy, result registers and the sticky error flag.
    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        f_d       = f_q;
        sat_d     = sat_q;
        f_valid_d = 1'b0;
        err_d     = err_q;

        if (push_ok) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (pop_ok) begin
            rptr_d    = rptr_q + PW'(1);
            f_d       = conv_f;
            sat_d     = conv_sat;
            f_valid_d = 1'b1;
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Overflow: a dropped push. Underflow: a magnitude with no sign to pair it with.
        if ((in_push_i && full && !mag_valid_i) || (mag_valid_i && empty && !in_push_i)) begin
            err_d = 1'b1;
        end
    end

    // Register state. Reset is synchronous, and inputs seen during reset are ignored.
    always_ff @(posedge clk_i) begin
        if (!reset_l_i) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            f_q       <= '0;
            f_valid_q <= 1'b0;
            sat_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            f_q       <= f_d;
            f_valid_q <= f_valid_d;
            sat_q     <= sat_d;
            err_q     <= err_d;
        end
    end

    // Write accepted signs into the slot addressed by the write pointer.
    always_ff @(posedge clk_i) begin
        if (reset_l_i && mem_we) begin
            mem_q[wptr_q] <= in_sign_i;
        end
    end

    assign in_full_o = full;
    assign count_o   = count_q;
    assign f_o       = f_q;
    assign f_valid_o = f_valid_q;
    assign sat_o     = sat_q;
    assign err_o     = err_q;

endmodule
